shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit bank of D flip-flops (shared register Q) among N_REQ requesters.
- Each requester raises Req and is granted exclusive write access to the register.
- The owner writes its data slice every cycle while it holds the grant; the grant is force-released after MAX_HOLD writes.
- Sits between lab-board input sources (switch/button front ends) and the shared output register that drives the display datapath.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, width of the shared register and of each requester's data slice.
- MAX_HOLD, 4, maximum consecutive writes per grant; legal range >= 1.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Req  input  N_REQ  request vector; bit i = requester i wants the register.
- Data  input  N_REQ*DATA_W  requester data, concatenated; slice i = Data[i*DATA_W +: DATA_W].
- Grant  output  N_REQ  registered one-hot grant; all-zero when idle.
- Owner  output  OW  registered index of the granted requester, where OW = clog2(N_REQ); holds its last value when idle.
- Busy  output  1  registered; high while in state BUSY.
- Q  output  DATA_W  shared register contents.
- Ack  output  N_REQ  registered one-hot pulse, one cycle wide; bit i is high in the cycle after requester i's data was written to Q.

Behaviour:
- Reset (async, any time, including mid-grant):
  - Grant=0, Owner=0, Busy=0, Q=0, Ack=0, state=IDLE, hold_cnt=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
  - No write occurs on the edge where Reset is high.
- State IDLE:
  - Grant=0, Busy=0.
  - At an edge with Req != 0: winner = first set bit of Req searching (last+1), (last+2), ... mod N_REQ.
  - Next state BUSY; Grant=onehot(winner), Owner=winner, last=winner, hold_cnt=0.
  - No write to Q in this transition.
  - With Req==0, stay in IDLE.
- State BUSY, evaluated at each edge using Req[Owner]:
  - Req[Owner]=1 and hold_cnt < MAX_HOLD-1: Q <= Data slice Owner; Ack <= onehot(Owner); hold_cnt++; stay BUSY.
  - Req[Owner]=1 and hold_cnt == MAX_HOLD-1: perform the write and Ack as above, then forced release: next state IDLE, Grant<=0, Busy<=0.
  - Req[Owner]=0: no write, Ack<=0; voluntary release to IDLE, Grant<=0.
- Latency and timing:
  - Req rise to Grant: 1 edge.
  - Grant to first write: 1 edge.
  - Write to Ack: Ack is visible in the cycle following the write edge, coincident with the new Q.
- Gap cycle: every release passes through one IDLE cycle before the next grant. This gives fixed, checkable timing.
- Fairness: because last=previous owner, a force-released requester that still requests gets lowest priority on re-arbitration. No requester waits more than (N_REQ-1) grants.
- Ignored inputs: Req and Data of non-owners are ignored in BUSY. Req bits that drop in IDLE before sampling are never granted.
- Widths:
  - hold_cnt width = clog2(MAX_HOLD+1); it never wraps because it is cleared on every grant.
  - With MAX_HOLD=1, exactly one write per grant.
- Invariants:
  - Grant is zero or one-hot; Ack is zero or one-hot.
  - Ack is never high for a requester other than the one that performed the last write.
  - Q changes only on an edge where state=BUSY and Req[Owner]=1.

Test Plan:
- Reset check: assert Reset mid-BUSY with Q=8'hA5 -> Q, Grant, Ack and Busy go to 0 immediately, without waiting for Clk. After release with Req=4'b1111, Grant=4'b0001 one edge later.
- Single requester burst: Req=4'b0100, Data slice2=8'h3C held high 10 cycles, MAX_HOLD=4 -> Grant=4'b0100, then 4 writes with Q=8'h3C and Ack=4'b0100 for 4 cycles. Then 1 IDLE cycle, regrant, and the pattern repeats.
- Round-robin rotation: Req=4'b1111 held continuously -> grant order 0,1,2,3,0. Each grant gives exactly 4 writes, Q tracks each owner's slice, with one idle cycle between grants.
- Voluntary release: requester 1 granted, drops Req after 2 writes -> Q keeps the 2nd value, no Ack on the release edge, Busy falls next edge. A pending Req[3] is granted 1 edge later.
- Late/other requester: during requester 0's grant, Req[2] rises and Data slice2 changes every cycle -> Q never takes a slice2 value until Grant=4'b0100.
- MAX_HOLD=1 build, Req=4'b0011 -> grants alternate 0,1,0,1, one write each, Ack alternating 4'b0001/4'b0010 with idle gaps.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared DATA_W-bit
// register among N_REQ requesters, with a forced release after MAX_HOLD writes.
module shared_reg_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned OW      = $clog2(N_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*DATA_W-1:0]   Data,
  output logic [N_REQ-1:0]          Grant,
  output logic [OW-1:0]             Owner,
  output logic                      Busy,
  output logic [DATA_W-1:0]         Q,
  output logic [N_REQ-1:0]          Ack
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_RST  = OW'(N_REQ - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [OW-1:0]     last_q, last_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic              req_own;
  logic [DATA_W-1:0] data_own;
  logic              hi_found, lo_found;
  logic [OW-1:0]     hi_idx, lo_idx, win_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      r[i] = (idx == OW'(i));
    end
    return r;
  endfunction

  // Owner's request bit and data slice.
  always_comb begin
    req_own  = 1'b0;
    data_own = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        req_own  = Req[i];
        data_own = Data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotating priority split into two scans: indices above last win first,
  // then the wrap-around part (0..last) is searched.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (Req[i]) begin
        if (OW'(i) > last_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = OW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = OW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    q_d        = q_q;
    ack_d      = '0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          state_d    = ST_BUSY;
          grant_d    = onehot(win_idx);
          owner_d    = win_idx;
          last_d     = win_idx;
          hold_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (req_own) begin
          q_d   = data_own;
          ack_d = onehot(owner_q);
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      q_q        <= '0;
      ack_q      <= '0;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      q_q        <= q_d;
      ack_q      <= ack_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign Grant = grant_q;
  assign Owner = owner_q;
  assign Busy  = busy_q;
  assign Q     = q_q;
  assign Ack   = ack_q;

  assert property (@(posedge Clk) disable iff (Reset) $onehot0(grant_q));
  assert property (@(posedge Clk) disable iff (Reset) $onehot0(ack_q));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances checked
// every cycle against a grant/write-count model plus directed literal checks.
module tb_shared_reg_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  req0 = 4'b0000, req1 = 4'b0011;
  logic [31:0] data0 = '0, data1 = '0;
  logic [3:0]  grant0, grant1, ack0, ack1;
  logic [1:0]  owner0, owner1;
  logic        busy0, busy1;
  logic [7:0]  q0, q1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(req0), .Data(data0),
    .Grant(grant0), .Owner(owner0), .Busy(busy0), .Q(q0), .Ack(ack0)
  );

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Req(req1), .Data(data1),
    .Grant(grant1), .Owner(owner1), .Busy(busy1), .Q(q1), .Ack(ack1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who holds the register and how many writes it has made.
  int          mb[2], mo[2], mw[2], ml[2];
  int          hold[2] = '{4, 1};
  logic [7:0]  mq[2];
  logic [3:0]  mack[2];

  task automatic model_reset(input int i);
    mb[i] = 0; mo[i] = 0; mw[i] = 0; ml[i] = 3; mq[i] = '0; mack[i] = '0;
  endtask

  task automatic model_step(input int i, input logic [3:0] r, input logic [31:0] d);
    if (Reset) begin
      model_reset(i);
    end else if (mb[i] == 0) begin
      mack[i] = '0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (ml[i] + k) % 4;
        if (r[c]) begin
          mb[i] = 1; mo[i] = c; ml[i] = c; mw[i] = 0;
          break;
        end
      end
    end else if (r[mo[i]]) begin
      mq[i]   = d[mo[i]*8 +: 8];
      mack[i] = 4'b0001 << mo[i];
      mw[i]++;
      if (mw[i] == hold[i]) mb[i] = 0;
    end else begin
      mack[i] = '0;
      mb[i]   = 0;
    end
  endtask

  task automatic cmp(input int i, input logic [3:0] g, input logic [1:0] o, input logic b,
                     input logic [7:0] q, input logic [3:0] a);
    logic [3:0] eg;
    eg = (mb[i] != 0) ? (4'b0001 << mo[i]) : 4'b0000;
    chk($sformatf("dut%0d.Grant", i), 32'(g), 32'(eg));
    chk($sformatf("dut%0d.Owner", i), 32'(o), 32'(mo[i]));
    chk($sformatf("dut%0d.Busy", i), 32'(b), 32'(mb[i] != 0));
    chk($sformatf("dut%0d.Q", i), 32'(q), 32'(mq[i]));
    chk($sformatf("dut%0d.Ack", i), 32'(a), 32'(mack[i]));
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge Clk);
      model_step(0, req0, data0);
      model_step(1, req1, data1);
      #1;
      cmp(0, grant0, owner0, busy0, q0, ack0);
      cmp(1, grant1, owner1, busy1, q1, ack1);
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      data1 = $urandom;
    end
  end

  initial begin
    logic [3:0] order[5];
    logic [3:0] acks[4];
    logic [3:0] prev;
    int got, na;

    repeat (3) @(negedge Clk);
    chk("rst.Grant", 32'(grant0), 32'h0);
    chk("rst.Owner", 32'(owner0), 32'h0);
    chk("rst.Busy", 32'(busy0), 32'h0);
    chk("rst.Q", 32'(q0), 32'h0);
    chk("rst.Ack", 32'(ack0), 32'h0);

    // Single requester burst
    Reset = 1'b0;
    req0  = 4'b0100;
    data0 = 32'h443C2211;
    @(negedge Clk);
    chk("burst.Grant", 32'(grant0), 32'h4);
    chk("burst.Busy", 32'(busy0), 32'h1);
    for (int w = 0; w < 4; w++) begin
      @(negedge Clk);
      chk("burst.Q", 32'(q0), 32'h3C);
      chk("burst.Ack", 32'(ack0), 32'h4);
      chk("burst.GrantHold", 32'(grant0), (w == 3) ? 32'h0 : 32'h4);
    end
    @(negedge Clk);
    chk("burst.Regrant", 32'(grant0), 32'h4);
    req0 = 4'b0000;
    @(negedge Clk);
    chk("burst.RelAck", 32'(ack0), 32'h0);
    chk("burst.RelGrant", 32'(grant0), 32'h0);
    @(negedge Clk);

    // Asynchronous reset in the middle of a grant
    req0  = 4'b0001;
    data0 = 32'h000000A5;
    @(negedge Clk);
    @(negedge Clk);
    chk("arst.QBefore", 32'(q0), 32'hA5);
    #2 Reset = 1'b1;
    #1;
    chk("arst.Q", 32'(q0), 32'h0);
    chk("arst.Grant", 32'(grant0), 32'h0);
    chk("arst.Ack", 32'(ack0), 32'h0);
    chk("arst.Busy", 32'(busy0), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    req0  = 4'b1111;
    data0 = 32'hD4C3B2A1;
    @(negedge Clk);
    chk("arst.FirstGrant", 32'(grant0), 32'h1);

    // Round-robin rotation; MAX_HOLD=1 instance alternates meanwhile
    got = 0; na = 0; prev = '0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (grant0 != 4'b0000 && prev == 4'b0000) begin
        order[got] = grant0;
        got++;
      end
      if (ack1 != 4'b0000 && na < 4) begin
        acks[na] = ack1;
        na++;
      end
      prev = grant0;
      if (got < 5) @(negedge Clk);
    end
    chk("rr.GrantCount", 32'(got), 32'd5);
    chk("mh1.AckCount", 32'(na), 32'd4);
    for (int k = 0; k < 5; k++) chk("rr.Order", 32'(order[k]), 32'(4'b0001 << (k % 4)));
    for (int k = 0; k < 4; k++) chk("mh1.AckSeq", 32'(acks[k]), (k % 2 == 1) ? 32'h2 : 32'h1);
    req0 = 4'b0000;
    @(negedge Clk);
    @(negedge Clk);

    // Voluntary release with requester 3 pending
    req0  = 4'b1010;
    data0 = 32'h00005100;
    @(negedge Clk);
    chk("vol.Grant", 32'(grant0), 32'h2);
    @(negedge Clk);
    chk("vol.Q1", 32'(q0), 32'h51);
    chk("vol.Ack1", 32'(ack0), 32'h2);
    data0[15:8] = 8'h52;
    @(negedge Clk);
    chk("vol.Q2", 32'(q0), 32'h52);
    req0 = 4'b1000;
    @(negedge Clk);
    chk("vol.QHold", 32'(q0), 32'h52);
    chk("vol.RelAck", 32'(ack0), 32'h0);
    chk("vol.RelBusy", 32'(busy0), 32'h0);
    chk("vol.RelGrant", 32'(grant0), 32'h0);
    @(negedge Clk);
    chk("vol.NextGrant", 32'(grant0), 32'h8);
    req0 = 4'b0000;
    @(negedge Clk);
    @(negedge Clk);

    // Non-owner data is ignored
    req0  = 4'b0001;
    data0 = 32'h0000000F;
    @(negedge Clk);
    req0 = 4'b0101;
    for (int w = 0; w < 4; w++) begin
      data0[23:16] = 8'($urandom);
      @(negedge Clk);
      chk("late.Q", 32'(q0), 32'h0F);
    end
    data0[23:16] = 8'h77;
    @(negedge Clk);
    chk("late.Grant", 32'(grant0), 32'h4);
    chk("late.QHold", 32'(q0), 32'h0F);
    @(negedge Clk);
    chk("late.QSlice2", 32'(q0), 32'h77);
    req0 = 4'b0000;

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) req0 = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req1 = 4'($urandom);
      data0 = $urandom;
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
